// File: rtl/flex_timer_bank.sv
// flex_timer_bank: bank of independent up-counters with per-channel terminal
// value, periodic/one-shot modes, combinational cascade and a shared irq.
module flex_timer_bank #(
  parameter int NUM_CH       = 4,
  parameter int NUM_CNT_BITS = 8
) (
  input  logic                         clk,
  input  logic                         n_rst,
  input  logic [NUM_CH-1:0]            count_enable,
  input  logic [NUM_CH-1:0]            clear,
  input  logic [NUM_CH-1:0]            load,
  input  logic [NUM_CH*NUM_CNT_BITS-1:0] load_val,
  input  logic [NUM_CH*NUM_CNT_BITS-1:0] rollover_val,
  input  logic [NUM_CH-1:0]            one_shot,
  input  logic [NUM_CH-1:0]            chain_en,
  input  logic [NUM_CH-1:0]            irq_mask,
  output logic [NUM_CH*NUM_CNT_BITS-1:0] count_out,
  output logic [NUM_CH-1:0]            rollover_flag,
  output logic [NUM_CH-1:0]            wrap_pulse,
  output logic [NUM_CH-1:0]            done,
  output logic                         irq
);

  localparam int W = NUM_CNT_BITS;

  logic [NUM_CH*W-1:0] count_q, count_d;
  logic [NUM_CH-1:0]   flag_q, flag_d;
  logic [NUM_CH-1:0]   wrap_q, wrap_d;
  logic [NUM_CH-1:0]   done_q, done_d;
  logic                irq_q, irq_d;

  logic [NUM_CH-1:0]   inc;
  logic [NUM_CH-1:0]   term;

  // Increment requests and terminal events; a terminal event ripples into the
  // next channel's increment within the same cycle when that channel chains.
  always_comb begin
    logic          carry;
    logic          inc_i;
    logic          term_i;
    logic [W-1:0]  cnt;
    logic [W-1:0]  r;
    carry  = 1'b0;
    inc_i  = 1'b0;
    term_i = 1'b0;
    cnt    = '0;
    r      = '0;
    inc    = '0;
    term   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cnt    = count_q[i*W +: W];
      r      = rollover_val[i*W +: W];
      inc_i  = (i != 0 && chain_en[i]) ? carry : count_enable[i];
      term_i = inc_i && (cnt == r) && (r != '0) && !done_q[i];
      inc[i]  = inc_i;
      term[i] = term_i;
      carry   = term_i;
    end
  end

  // Per-channel next state: clear > load > terminal/increment > hold.
  always_comb begin
    logic [W-1:0] cnt;
    logic [W-1:0] r;
    logic [W-1:0] lv;
    logic [W-1:0] cnt_inc;
    count_d = count_q;
    flag_d  = flag_q;
    done_d  = done_q;
    wrap_d  = '0;
    cnt     = '0;
    r       = '0;
    lv      = '0;
    cnt_inc = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cnt     = count_q[i*W +: W];
      r       = rollover_val[i*W +: W];
      lv      = load_val[i*W +: W];
      cnt_inc = cnt + W'(1);
      if (clear[i]) begin
        count_d[i*W +: W] = '0;
        flag_d[i]         = 1'b0;
        done_d[i]         = 1'b0;
      end else if (load[i]) begin
        count_d[i*W +: W] = lv;
        flag_d[i]         = (lv == r) && (r != '0);
        done_d[i]         = 1'b0;
      end else if (term[i]) begin
        wrap_d[i] = 1'b1;
        if (one_shot[i]) begin
          // count parks at R; flag stays asserted while parked
          done_d[i] = 1'b1;
          flag_d[i] = 1'b1;
        end else begin
          count_d[i*W +: W] = W'(1);
          flag_d[i]         = (r == W'(1));
        end
      end else if (inc[i] && !done_q[i] && (r != '0)) begin
        // count != R here; values above R wrap through 0 silently
        count_d[i*W +: W] = cnt_inc;
        flag_d[i]         = (cnt_inc == r);
      end
    end
  end

  // Interrupt follows the registered pulses by one cycle.
  always_comb begin
    irq_d = |(wrap_q & irq_mask);
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= '0;
      flag_q  <= '0;
      wrap_q  <= '0;
      done_q  <= '0;
      irq_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      flag_q  <= flag_d;
      wrap_q  <= wrap_d;
      done_q  <= done_d;
      irq_q   <= irq_d;
    end
  end

  assign count_out     = count_q;
  assign rollover_flag = flag_q;
  assign wrap_pulse    = wrap_q;
  assign done          = done_q;
  assign irq           = irq_q;

endmodule

// File: doc/flex_timer_bank.md
FLEX_TIMER_BANK -- requirements
Module: flex_timer_bank

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent counter channels, 1..16.
REQ-002 Parameter NUM_CNT_BITS, default 8: counter width W per channel, 2..32.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 n_rst  input  1  reset, asynchronous, active-low.
REQ-005 count_enable  input  NUM_CH  per-channel increment request.
REQ-006 clear  input  NUM_CH  per-channel synchronous clear.
REQ-007 load  input  NUM_CH  per-channel synchronous load of load_val.
REQ-008 load_val  input  NUM_CH*W  packed load values; channel i occupies bits [i*W +: W].
REQ-009 rollover_val  input  NUM_CH*W  packed terminal values R[i], same packing.
REQ-010 one_shot  input  NUM_CH  per-channel mode: 0 periodic, 1 one-shot.
REQ-011 chain_en  input  NUM_CH  per-channel cascade select; bit 0 ignored.
REQ-012 irq_mask  input  NUM_CH  per-channel interrupt enable.
REQ-013 count_out  output  NUM_CH*W  packed current counts.
REQ-014 rollover_flag  output  NUM_CH  per-channel registered at-terminal flag.
REQ-015 wrap_pulse  output  NUM_CH  per-channel one-cycle terminal-event pulse.
REQ-016 done  output  NUM_CH  per-channel one-shot expired, level.
REQ-017 irq  output  1  registered OR of (wrap_pulse & irq_mask).

Function
REQ-018 Each channel SHALL be independent except for cascade (REQ-024); every output SHALL be registered.
REQ-019 Per channel, inc = chain_en[i] ? term[i-1] : count_enable[i] for i>0; inc = count_enable[0] for i=0.
REQ-020 term[i] (combinational) SHALL be inc[i] & (count==R[i]) & (R[i]!=0) & !done[i].
REQ-021 Priority per channel, per cycle: clear > load > inc > hold.
REQ-022 clear: count<=0, rollover_flag<=0, done<=0, wrap_pulse<=0.
REQ-023 load: count<=load_val, rollover_flag<=(load_val==R & R!=0), done<=0, wrap_pulse<=0.
REQ-024 Cascade: term ripples combinationally within the same cycle, so a channel-0 terminal event may advance channel 1, then 2, in one clock.
REQ-025 inc with count!=R: count<=count+1 modulo 2^W; rollover_flag<=(count+1==R).
REQ-026 Periodic term: count<=1, rollover_flag<=(R==1), wrap_pulse<=1 for exactly one cycle.
REQ-027 One-shot term: count holds R, done<=1, wrap_pulse<=1 for one cycle, rollover_flag stays 1.
REQ-028 While done=1, inc SHALL be ignored and count, rollover_flag held until clear or load.
REQ-029 R==0: channel SHALL hold count, never assert rollover_flag, wrap_pulse, done; clear/load still act.
REQ-030 Count above R, e.g. after a load, SHALL increment, wrap 2^W-1 -> 0 with no event, and reach R normally.
REQ-031 R changed mid-count SHALL take effect on the next compare; no retroactive event.
REQ-032 wrap_pulse not re-triggered in the following cycle SHALL return to 0.
REQ-033 irq SHALL be the OR of (wrap_pulse & irq_mask), registered one cycle after wrap_pulse.
REQ-034 Hold with no clear/load/inc: all state unchanged; wrap_pulse<=0.

Reset
REQ-035 n_rst low SHALL immediately force count_out=0, rollover_flag=0, wrap_pulse=0, done=0, irq=0, independent of clk.
REQ-036 Reset deassertion SHALL permit counting from the first following clk edge; reset mid-count discards all state.

Verification (NUM_CH=2, W=4)
REQ-037 Ch0 R=5 periodic, count_enable held from 0 -> count 1,2,3,4,5,1,2; flag high only while count=5; wrap_pulse high the cycle count=1 after 5; irq one cycle later when irq_mask[0]=1.
REQ-038 Ch0 R=3 one-shot, enable held -> 1,2,3,3,3...; done=1 and single wrap_pulse one cycle after the first enabled cycle at 3; load_val=0 then restarts.
REQ-039 Clear, load (load_val=9) and enable in one cycle -> count 0; load plus enable without clear -> count 9.
REQ-040 Ch0 R=3 periodic, ch1 chain_en=1, R=2, count_enable[1]=1 -> ch1 advances once per ch0 wrap, 0,1,2,1; ch1 wrap_pulse coincident with every second ch0 wrap_pulse.
REQ-041 R=0, enable toggled 20 cycles -> count stays 0, no flag, pulse or done; then load_val=14 with R=2 -> counts 15,0,1,2, flag at 2, wrap then to 1.
REQ-042 n_rst pulsed low asynchronously at count=4 between edges -> all outputs 0 immediately; counting resumes 1,2... after release.
